// File: rtl/mem_access_stage_pkg.sv
// Shared instruction ids, memory-stage FSM encoding and bus payload type.
package mem_access_stage_pkg;

   localparam int unsigned ID_W   = 6;
   localparam int unsigned XLEN   = 32;
   localparam int unsigned STRB_W = XLEN / 8;

   typedef logic [ID_W-1:0] instr_id_t;

   localparam instr_id_t ID_NOP = 6'd0;
   localparam instr_id_t ID_ADD = 6'd1;
   localparam instr_id_t ID_SUB = 6'd2;
   localparam instr_id_t ID_AND = 6'd3;
   localparam instr_id_t ID_OR  = 6'd4;
   localparam instr_id_t ID_XOR = 6'd5;
   localparam instr_id_t ID_LB  = 6'd16;
   localparam instr_id_t ID_LH  = 6'd17;
   localparam instr_id_t ID_LW  = 6'd18;
   localparam instr_id_t ID_LBU = 6'd19;
   localparam instr_id_t ID_LHU = 6'd20;
   localparam instr_id_t ID_SB  = 6'd24;
   localparam instr_id_t ID_SH  = 6'd25;
   localparam instr_id_t ID_SW  = 6'd26;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } mem_state_e;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } access_size_e;

   typedef struct packed {
      logic              we;
      logic [XLEN-1:0]   addr;
      logic [XLEN-1:0]   wdata;
      logic [STRB_W-1:0] wstrb;
   } bus_fields_t;

   function automatic logic is_load(instr_id_t id);
      return (id == ID_LB) || (id == ID_LH) || (id == ID_LW) ||
             (id == ID_LBU) || (id == ID_LHU);
   endfunction

   function automatic logic is_store(instr_id_t id);
      return (id == ID_SB) || (id == ID_SH) || (id == ID_SW);
   endfunction

   function automatic access_size_e access_size(instr_id_t id);
      access_size_e sz;
      sz = SZ_BYTE;
      if ((id == ID_LH) || (id == ID_LHU) || (id == ID_SH)) sz = SZ_HALF;
      if ((id == ID_LW) || (id == ID_SW)) sz = SZ_WORD;
      return sz;
   endfunction

   // Halfwords need an even address, words a 4-byte aligned one.
   function automatic logic is_misaligned(instr_id_t id, logic [1:0] addr_lo);
      logic mis;
      mis = 1'b0;
      unique case (access_size(id))
         SZ_HALF: mis = addr_lo[0];
         SZ_WORD: mis = (addr_lo != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/mem_align_unit.sv
// Store lane replication/strobes and load byte/half extraction with extension.
module mem_align_unit
   import mem_access_stage_pkg::*;
(
   input  logic [5:0]  instr_id,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_data,
   input  logic [31:0] load_word,
   output logic [31:0] wdata_c,
   output logic [3:0]  wstrb_c,
   output logic [31:0] load_c
);

   logic [31:0] shifted;

   always_comb begin : p_align
      wdata_c = '0;
      wstrb_c = '0;
      load_c  = '0;
      // Bring the addressed lane down to bit 0 before extending.
      shifted = load_word >> {addr_lo, 3'b000};
      unique case (instr_id)
         ID_SB: begin
            wdata_c = {4{store_data[7:0]}};
            wstrb_c = 4'b0001 << addr_lo;
         end
         ID_SH: begin
            wdata_c = {2{store_data[15:0]}};
            wstrb_c = 4'b0011 << addr_lo;
         end
         ID_SW: begin
            wdata_c = store_data;
            wstrb_c = 4'b1111;
         end
         ID_LB:   load_c = {{24{shifted[7]}}, shifted[7:0]};
         ID_LBU:  load_c = {24'b0, shifted[7:0]};
         ID_LH:   load_c = {{16{shifted[15]}}, shifted[15:0]};
         ID_LHU:  load_c = {16'b0, shifted[15:0]};
         ID_LW:   load_c = shifted;
         default: load_c = '0;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline memory stage: issues loads/stores on a req/ack bus, stalls upstream
// while an access is outstanding, and drives the MEM/WB register inputs.
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned CNT_W          = 7
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid_in,
   input  logic [5:0]  instr_id_in,
   input  logic [31:0] mem_addr_in,
   input  logic [31:0] rs2_value_in,
   input  logic [31:0] exec_output_in,
   input  logic [4:0]  rd_addr_in,
   input  logic        rd_valid_in,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wstrb,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        stall_out,
   output logic        valid_out,
   output logic [4:0]  rd_addr_out,
   output logic        rd_valid_out,
   output logic [31:0] wb_data_out,
   output logic        misalign_out,
   output logic        bus_err_out
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   mem_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;
   logic [31:0]       data_q, data_d;
   logic              bus_req_q, bus_req_d;
   bus_fields_t       bus_q, bus_d;

   logic        mem_op;
   logic        misaligned;
   logic        issue;
   logic        op_is_load;
   logic [31:0] align_wdata;
   logic [3:0]  align_wstrb;
   logic [31:0] align_load;

   mem_align_unit u_align (
      .instr_id   (instr_id_in),
      .addr_lo    (mem_addr_in[1:0]),
      .store_data (rs2_value_in),
      .load_word  (bus_rdata),
      .wdata_c    (align_wdata),
      .wstrb_c    (align_wstrb),
      .load_c     (align_load)
   );

   always_comb begin : p_decode
      op_is_load = is_load(instr_id_in);
      mem_op     = valid_in && (op_is_load || is_store(instr_id_in));
      misaligned = mem_op && is_misaligned(instr_id_in, mem_addr_in[1:0]);
      issue      = mem_op && !misaligned;
   end

   // Next-state: EX/MEM holds the op stable while stalled, so WAIT reads the inputs directly.
   always_comb begin : p_next
      state_d   = state_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      data_d    = data_q;
      bus_req_d = bus_req_q;
      bus_d     = bus_q;
      unique case (state_q)
         ST_IDLE: begin
            if (issue) begin
               bus_req_d   = 1'b1;
               bus_d.we    = is_store(instr_id_in);
               bus_d.addr  = {mem_addr_in[31:2], 2'b00};
               bus_d.wdata = align_wdata;
               bus_d.wstrb = align_wstrb;
               cnt_d       = '0;
               err_d       = 1'b0;
               data_d      = '0;
               state_d     = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus_ack) begin
               bus_req_d = 1'b0;
               data_d    = op_is_load ? align_load : 32'h0;
               state_d   = ST_RESP;
            end else if (cnt_q == CNT_LAST) begin
               bus_req_d = 1'b0;
               err_d     = 1'b1;
               state_d   = ST_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin : p_regs
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         data_q    <= '0;
         bus_req_q <= 1'b0;
         bus_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         data_q    <= data_d;
         bus_req_q <= bus_req_d;
         bus_q     <= bus_d;
      end
   end

   // Pipeline-facing outputs: pass-through in IDLE, result slot in RESP.
   always_comb begin : p_out
      stall_out    = 1'b0;
      valid_out    = 1'b0;
      rd_addr_out  = rd_addr_in;
      rd_valid_out = 1'b0;
      wb_data_out  = exec_output_in;
      misalign_out = 1'b0;
      bus_err_out  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (issue) begin
               stall_out = 1'b1;
            end else if (misaligned) begin
               valid_out    = 1'b1;
               misalign_out = 1'b1;
            end else begin
               valid_out    = valid_in;
               rd_valid_out = rd_valid_in;
            end
         end
         ST_WAIT: stall_out = 1'b1;
         ST_RESP: begin
            valid_out    = 1'b1;
            wb_data_out  = data_q;
            rd_valid_out = op_is_load && rd_valid_in && !err_q;
            bus_err_out  = err_q;
         end
         default: stall_out = 1'b0;
      endcase
   end

   assign bus_req   = bus_req_q;
   assign bus_we    = bus_q.we;
   assign bus_addr  = bus_q.addr;
   assign bus_wdata = bus_q.wdata;
   assign bus_wstrb = bus_q.wstrb;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: transaction-level reference model,
// per-cycle output comparison, directed scenarios and randomized traffic.
module tb_mem_access_stage;
   import mem_access_stage_pkg::*;

   localparam int unsigned TIMEOUT = 64;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_in;
   logic [5:0]  instr_id_in;
   logic [31:0] mem_addr_in;
   logic [31:0] rs2_value_in;
   logic [31:0] exec_output_in;
   logic [4:0]  rd_addr_in;
   logic        rd_valid_in;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_wstrb;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        stall_out;
   logic        valid_out;
   logic [4:0]  rd_addr_out;
   logic        rd_valid_out;
   logic [31:0] wb_data_out;
   logic        misalign_out;
   logic        bus_err_out;

   always #5 clk = ~clk;

   mem_access_stage #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(7)) dut (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .instr_id_in(instr_id_in),
      .mem_addr_in(mem_addr_in), .rs2_value_in(rs2_value_in),
      .exec_output_in(exec_output_in), .rd_addr_in(rd_addr_in),
      .rd_valid_in(rd_valid_in), .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata), .stall_out(stall_out),
      .valid_out(valid_out), .rd_addr_out(rd_addr_out), .rd_valid_out(rd_valid_out),
      .wb_data_out(wb_data_out), .misalign_out(misalign_out), .bus_err_out(bus_err_out)
   );

   int n_checks = 0;
   int n_fails  = 0;

   // Reference model: one outstanding transaction, or a result waiting to retire.
   bit          m_busy, m_resp, m_timed_out, m_is_load;
   int          m_wait_n;
   logic [31:0] m_result, m_addr, m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_we;
   logic [5:0]  m_id;

   // Bus responder: ack on wait cycle ack_at (1-based), never when <= 0.
   int          ack_at;
   logic [31:0] ack_data;
   bit          stray_en, force_ack;
   bit          cur_stall;

   // What the bench saw during the last op.
   int          r_stall, r_req, r_mis, r_err, r_valid;
   logic [31:0] r_wb, r_addr, r_wdata;
   logic [3:0]  r_wstrb;
   logic        r_we, r_rdv;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int op_bytes(logic [5:0] id);
      case (id)
         ID_LB, ID_LBU, ID_SB: return 1;
         ID_LH, ID_LHU, ID_SH: return 2;
         ID_LW, ID_SW:         return 4;
         default:              return 0;
      endcase
   endfunction

   function automatic bit op_store(logic [5:0] id);
      return (id == ID_SB) || (id == ID_SH) || (id == ID_SW);
   endfunction

   function automatic bit op_signed(logic [5:0] id);
      return (id == ID_LB) || (id == ID_LH);
   endfunction

   function automatic logic [31:0] ref_load(logic [5:0] id, logic [31:0] addr, logic [31:0] rdata);
      int          n;
      logic [31:0] v;
      n = op_bytes(id);
      v = rdata >> (8 * 32'(addr % 4));
      if (n == 4) return v;
      v = v & ((32'h1 << (8 * n)) - 32'h1);
      if (op_signed(id) && v[8 * n - 1]) v = v - (32'h1 << (8 * n));
      return v;
   endfunction

   function automatic logic [31:0] ref_wdata(logic [5:0] id, logic [31:0] rs2);
      case (op_bytes(id))
         1:       return (rs2 & 32'hFF) * 32'h0101_0101;
         2:       return (rs2 & 32'hFFFF) * 32'h0001_0001;
         default: return rs2;
      endcase
   endfunction

   function automatic logic [3:0] ref_wstrb(logic [5:0] id, logic [31:0] addr);
      int n;
      n = op_bytes(id);
      if (n == 4) return 4'hF;
      return 4'(((1 << n) - 1) << (addr % 4));
   endfunction

   task automatic model_reset();
      m_busy = 0; m_resp = 0; m_timed_out = 0; m_wait_n = 0; m_result = '0;
   endtask

   // One clock: drive bus, check outputs at negedge, advance the model at posedge.
   task automatic cycle();
      bit          mem, mis, issue;
      int          n;
      bit          e_req, e_stall, e_valid, e_rdv, e_mis, e_err;
      logic [31:0] e_wb;
      if (m_busy && ack_at > 0 && m_wait_n == ack_at) begin
         bus_ack = 1'b1; bus_rdata = ack_data;
      end else begin
         bus_ack   = !m_busy && (force_ack || (stray_en && $urandom_range(0, 3) == 0));
         bus_rdata = $urandom;
      end
      n   = op_bytes(instr_id_in);
      mem = valid_in && (n != 0);
      mis = 0;
      if (mem) mis = (mem_addr_in % 32'(n)) != 0;
      issue = !m_busy && !m_resp && mem && !mis;
      e_req = m_busy; e_stall = 0; e_valid = 0; e_rdv = 0; e_mis = 0; e_err = 0;
      e_wb  = exec_output_in;
      if (m_busy) e_stall = 1;
      else if (m_resp) begin
         e_valid = 1; e_wb = m_result; e_err = m_timed_out;
         e_rdv   = m_is_load && rd_valid_in && !m_timed_out;
      end else if (issue) e_stall = 1;
      else if (mis) begin e_valid = 1; e_mis = 1; end
      else begin e_valid = valid_in; e_rdv = rd_valid_in; end
      cur_stall = e_stall;

      @(negedge clk);
      check("stall_out", 32'(stall_out), 32'(e_stall));
      check("valid_out", 32'(valid_out), 32'(e_valid));
      check("misalign_out", 32'(misalign_out), 32'(e_mis));
      check("bus_err_out", 32'(bus_err_out), 32'(e_err));
      check("bus_req", 32'(bus_req), 32'(e_req));
      if (e_valid) begin
         check("rd_addr_out", 32'(rd_addr_out), 32'(rd_addr_in));
         check("rd_valid_out", 32'(rd_valid_out), 32'(e_rdv));
         check("wb_data_out", wb_data_out, e_wb);
      end
      if (e_req) begin
         check("bus_we", 32'(bus_we), 32'(m_we));
         check("bus_addr", bus_addr, m_addr);
         check("bus_wdata", bus_wdata, m_wdata);
         check("bus_wstrb", 32'(bus_wstrb), 32'(m_wstrb));
      end
      if (stall_out) r_stall++;
      if (bus_req) begin
         if (r_req == 0) begin
            r_addr = bus_addr; r_wdata = bus_wdata; r_wstrb = bus_wstrb; r_we = bus_we;
         end
         r_req++;
      end
      if (misalign_out) r_mis++;
      if (bus_err_out) r_err++;
      if (valid_out) begin r_valid++; r_wb = wb_data_out; r_rdv = rd_valid_out; end

      @(posedge clk);
      if (!rst_n) model_reset();
      else if (m_resp) m_resp = 0;
      else if (m_busy) begin
         if (bus_ack) begin
            m_busy = 0; m_resp = 1; m_timed_out = 0;
            m_result = m_is_load ? ref_load(m_id, m_addr | (mem_addr_in & 32'h3), bus_rdata) : 32'h0;
         end else if (m_wait_n == TIMEOUT) begin
            m_busy = 0; m_resp = 1; m_timed_out = 1; m_result = 32'h0;
         end else m_wait_n++;
      end else if (issue) begin
         m_busy = 1; m_wait_n = 1; m_id = instr_id_in; m_is_load = !op_store(instr_id_in);
         m_addr  = mem_addr_in & ~32'h3;
         m_we    = op_store(instr_id_in);
         m_wdata = m_is_load ? 32'h0 : ref_wdata(instr_id_in, rs2_value_in);
         m_wstrb = m_is_load ? 4'h0 : ref_wstrb(instr_id_in, mem_addr_in);
      end
      #1;
   endtask

   task automatic set_op(logic [5:0] id, logic [31:0] addr, logic [31:0] rs2,
                         logic [31:0] exec, logic [4:0] rd, logic rdv, logic vld);
      instr_id_in = id; mem_addr_in = addr; rs2_value_in = rs2;
      exec_output_in = exec; rd_addr_in = rd; rd_valid_in = rdv; valid_in = vld;
   endtask

   // Present one op and hold it until the stage stops stalling.
   task automatic run_op(logic [5:0] id, logic [31:0] addr, logic [31:0] rs2,
                         logic [31:0] exec, logic [4:0] rd, logic rdv, logic vld,
                         int lat, logic [31:0] rdata);
      int guard;
      set_op(id, addr, rs2, exec, rd, rdv, vld);
      ack_at = lat; ack_data = rdata;
      r_stall = 0; r_req = 0; r_mis = 0; r_err = 0; r_valid = 0;
      r_wb = 'x; r_rdv = 1'bx;
      guard = 0;
      do begin
         cycle();
         guard++;
      end while (cur_stall && guard < 200);
      check("op completes within bound", 32'(guard < 200), 32'(1));
   endtask

   logic [5:0] ids [10];

   initial begin
      ids = '{ID_ADD, ID_SUB, ID_LB, ID_LH, ID_LW, ID_LBU, ID_LHU, ID_SB, ID_SH, ID_SW};
      rst_n = 1'b0; stray_en = 0; force_ack = 0; ack_at = 0; ack_data = '0;
      bus_ack = 1'b0; bus_rdata = '0;
      set_op(ID_NOP, '0, '0, '0, '0, 1'b0, 1'b0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("reset bus_req", 32'(bus_req), 32'h0);
      check("reset bus_addr", bus_addr, 32'h0);
      check("reset bus_wdata", bus_wdata, 32'h0);
      check("reset bus_wstrb", 32'(bus_wstrb), 32'h0);
      check("reset bus_we", 32'(bus_we), 32'h0);
      check("reset stall_out", 32'(stall_out), 32'h0);
      check("reset bus_err_out", 32'(bus_err_out), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cycle();

      // LW, ack on the third wait cycle.
      run_op(ID_LW, 32'h100, 32'h0, 32'h0, 5'd3, 1'b1, 1'b1, 3, 32'hDEAD_BEEF);
      check("lw stall cycles", 32'(r_stall), 32'd4);
      check("lw wb_data", r_wb, 32'hDEAD_BEEF);
      check("lw rd_valid", 32'(r_rdv), 32'h1);

      run_op(ID_LB, 32'h103, 32'h0, 32'h0, 5'd4, 1'b1, 1'b1, 1, 32'h80FF_0000);
      check("lb sign extend", r_wb, 32'hFFFF_FF80);
      check("zero-wait stall cycles", 32'(r_stall), 32'd2);
      run_op(ID_LBU, 32'h103, 32'h0, 32'h0, 5'd4, 1'b1, 1'b1, 2, 32'h80FF_0000);
      check("lbu zero extend", r_wb, 32'h0000_0080);

      run_op(ID_SH, 32'h202, 32'h1234_ABCD, 32'h0, 5'd6, 1'b1, 1'b1, 1, 32'h0);
      check("sh bus_addr", r_addr, 32'h200);
      check("sh bus_wdata", r_wdata, 32'hABCD_ABCD);
      check("sh bus_wstrb", 32'(r_wstrb), 32'hC);
      check("sh bus_we", 32'(r_we), 32'h1);
      check("sh rd_valid", 32'(r_rdv), 32'h0);

      run_op(ID_LW, 32'h101, 32'h0, 32'h55, 5'd7, 1'b1, 1'b1, 1, 32'h0);
      check("misaligned pulse", 32'(r_mis), 32'd1);
      check("misaligned no req", 32'(r_req), 32'd0);
      check("misaligned no stall", 32'(r_stall), 32'd0);
      check("misaligned rd_valid", 32'(r_rdv), 32'h0);

      run_op(ID_SW, 32'h300, 32'h7777_8888, 32'h0, 5'd8, 1'b0, 1'b1, 0, 32'h0);
      check("timeout req cycles", 32'(r_req), 32'(TIMEOUT));
      check("timeout err pulses", 32'(r_err), 32'd1);
      check("timeout stall cycles", 32'(r_stall), 32'(TIMEOUT + 1));
      run_op(ID_ADD, 32'h0, 32'h0, 32'hCAFE_0001, 5'd9, 1'b1, 1'b1, 0, 32'h0);
      check("add after timeout valid", 32'(r_valid), 32'd1);
      check("add after timeout wb", r_wb, 32'hCAFE_0001);
      check("add after timeout no err", 32'(r_err), 32'd0);

      // Reset in the middle of WAIT, then a stray ack once idle.
      set_op(ID_LW, 32'h400, 32'h0, 32'h0, 5'd10, 1'b1, 1'b1);
      ack_at = 0;
      repeat (3) cycle();
      rst_n = 1'b0; valid_in = 1'b0; model_reset();
      #1;
      check("mid-wait reset bus_req", 32'(bus_req), 32'h0);
      check("mid-wait reset stall", 32'(stall_out), 32'h0);
      check("mid-wait reset bus_addr", bus_addr, 32'h0);
      cycle();
      rst_n = 1'b1; force_ack = 1;
      cycle();
      check("stray ack ignored", 32'(bus_req), 32'h0);
      force_ack = 0;
      run_op(ID_LW, 32'h404, 32'h0, 32'h0, 5'd11, 1'b1, 1'b1, 1, 32'h1122_3344);
      check("lw after reset stall", 32'(r_stall), 32'd2);
      check("lw after reset wb", r_wb, 32'h1122_3344);

      // Randomized traffic with stray acks outside outstanding accesses.
      stray_en = 1;
      for (int k = 0; k < 250; k++) begin
         logic [5:0]  id;
         logic [31:0] addr;
         int          lat, sel, n;
         id   = ids[$urandom_range(0, 9)];
         addr = $urandom;
         n    = op_bytes(id);
         if (n != 0 && $urandom_range(0, 3) != 0) addr = addr & ~32'(n - 1);
         sel = $urandom_range(0, 24);
         if (sel == 0)      lat = 0;
         else if (sel == 1) lat = TIMEOUT;
         else               lat = $urandom_range(1, 5);
         run_op(id, addr, $urandom, $urandom, 5'($urandom), 1'($urandom),
                1'($urandom_range(0, 9) != 0), lat, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the 5-stage core. Sits directly downstream of the EX/MEM pipeline register, consumes its outputs and drives the MEM/WB register inputs.
- Executes loads and stores over a req/ack data bus. Waits any number of cycles for the bus, with a timeout.
- Aligns and sign/zero-extends load data, builds byte strobes for stores, and stalls the upstream pipeline while a bus access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 64, cycles to wait for bus_ack before aborting with bus_err_out.
- CNT_W, 7, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  core clock (one clock)
- rst_n  in  1  reset, asynchronous and active-low
- valid_in  in  1  EX/MEM slot holds a real instruction
- instr_id_in  in  6  decoded instruction id (shared package encoding)
- mem_addr_in  in  32  effective address
- rs2_value_in  in  32  store data
- exec_output_in  in  32  ALU result for non-memory ops
- rd_addr_in  in  5  destination register
- rd_valid_in  in  1  instruction writes rd
- bus_req  out  1  bus request
- bus_we  out  1  1 = write
- bus_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- bus_wdata  out  32  store data, replicated into lanes
- bus_wstrb  out  4  byte enables
- bus_ack  in  1  one-cycle completion pulse
- bus_rdata  in  32  read word, valid when bus_ack=1
- stall_out  out  1  hold EX/MEM and all earlier stages
- valid_out  out  1  result slot valid, to MEM/WB
- rd_addr_out  out  5  to MEM/WB
- rd_valid_out  out  1  to MEM/WB
- wb_data_out  out  32  writeback value
- misalign_out  out  1  one-cycle fault pulse, misaligned access
- bus_err_out  out  1  one-cycle fault pulse, timeout

Behaviour:
- Reset value of all registered outputs and of the FSM state is 0/IDLE:
  - bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, fault pulses, timeout counter, captured data.
  - Assertion mid-access aborts immediately. After reset the pending request is forgotten, and a late bus_ack in IDLE is ignored.
- mem_op = valid_in & instr_id_in in {LB, LH, LW, LBU, LHU, SB, SH, SW}.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - No bus request, no stall.
  - misalign_out=1 for that cycle; valid_out=1; rd_valid_out=0.
- States: IDLE, WAIT, RESP.
- IDLE:
  - Non-mem ops pass through combinationally: valid_out=valid_in, wb_data_out=exec_output_in, rd fields from the inputs, stall_out=0.
  - Aligned mem_op: stall_out=1 combinationally and valid_out=0. At the clock edge, register the bus_* fields, set bus_req=1, clear the counter, and go to WAIT.
- WAIT:
  - bus_req stays 1 and bus fields stay stable; stall_out=1.
  - On bus_ack: drop bus_req, capture the aligned/extended load result, go to RESP.
  - Without ack, the counter increments each cycle. When the counter reaches TIMEOUT_CYCLES-1 without an ack: drop bus_req, set the error flag, go to RESP.
- RESP (exactly one cycle):
  - stall_out=0; valid_out=1.
  - Loads: rd_valid_out=rd_valid_in and wb_data_out=captured value.
  - Stores: rd_valid_out=0.
  - On timeout: rd_valid_out=0 and bus_err_out=1.
  - Next state is IDLE. EX/MEM advances on this edge, so the op still on the inputs is never re-issued.
- Store lanes by addr[1:0]:
  - SB: wdata={4{rs2[7:0]}}, wstrb=0001<<addr[1:0].
  - SH: wdata={2{rs2[15:0]}}, wstrb=0011<<addr[1:0].
  - SW: wstrb=1111.
- Loads:
  - Select the byte/half from bus_rdata using addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Loads assert bus_we=0 and bus_wstrb=0000.
- Fixed latency: 1 issue edge + N ack cycles + 1 RESP cycle. A zero-wait bus (ack on the first WAIT cycle) stalls exactly 2 cycles.

Decomposition:
- Instruction id constants (LB..SW, etc.) come from the core's shared instruction-definitions package.
- Add the FSM state encoding to that package.
- One natural sub-module: mem_align_unit. It is combinational and produces the store wdata/wstrb and the load extract/extend from instr_id, addr[1:0] and the data.

Test Plan:
- LW at 0x100, ack after 3 cycles with rdata=0xDEADBEEF -> stall_out high 4 cycles, then RESP with valid_out=1, wb_data_out=0xDEADBEEF.
- LB at 0x103 with rdata=0x80FF_0000 -> wb_data_out=0xFFFFFF80. LBU, same address and data -> 0x00000080.
- SH at 0x202, rs2=0x1234ABCD -> bus_addr=0x200, bus_wdata=0xABCDABCD, bus_wstrb=1100, bus_we=1, rd_valid_out=0 in RESP.
- LW at 0x101 -> misalign_out pulse, no bus_req, stall_out=0, rd_valid_out=0.
- SW with bus_ack never asserted, TIMEOUT_CYCLES=64 -> bus_req drops after 64 WAIT cycles, bus_err_out pulses once, and the next ADD passes through the following cycle.
- rst_n low mid-WAIT with a later stray bus_ack -> all outputs 0, FSM stays IDLE, and the next LW issues normally.
